// File: rtl/sd_fifo_pair_if.sv
// Data and handshake bundle between the Wishbone-side controller and the TX/RX FIFO pair.
// The master is the controller side; the slave is the FIFO pair.
interface sd_fifo_pair_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] tx_data_in;
  logic              tx_write_en;
  logic              tx_read_en;
  logic [DATA_W-1:0] tx_q_out;
  logic [DATA_W-1:0] rx_data_in;
  logic              rx_write_en;
  logic              rx_read_en;
  logic [DATA_W-1:0] rx_q_out;
  logic [1:0]        flush_in;
  logic              err_clear_in;
  logic [3:0]        status_out;
  logic [3:0]        almost_out;
  logic [LVL_W-1:0]  tx_level_out;
  logic [LVL_W-1:0]  rx_level_out;
  logic [3:0]        err_out;

  modport master (
    output tx_data_in, tx_write_en, tx_read_en,
    output rx_data_in, rx_write_en, rx_read_en,
    output flush_in, err_clear_in,
    input  tx_q_out, rx_q_out, status_out, almost_out,
    input  tx_level_out, rx_level_out, err_out
  );

  modport slave (
    input  tx_data_in, tx_write_en, tx_read_en,
    input  rx_data_in, rx_write_en, rx_read_en,
    input  flush_in, err_clear_in,
    output tx_q_out, rx_q_out, status_out, almost_out,
    output tx_level_out, rx_level_out, err_out
  );
endinterface

// File: rtl/sd_fifo_pair.sv
// Single-clock TX/RX FIFO pair between the Wishbone slave and the SD data path.
// Each channel has registered read data, level-derived flags, flush and sticky error flags.
module sd_fifo_chan #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  localparam int LVL_W    = $clog2(DEPTH + 1),
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_write_en,
  input  logic              i_read_en,
  input  logic              i_flush,
  input  logic              i_err_clear,
  output logic [DATA_W-1:0] o_q,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_af,
  output logic              o_ae,
  output logic              o_ovf,
  output logic              o_udf
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_q;
  logic              r_full;
  logic              r_empty;
  logic              r_af;
  logic              r_ae;
  logic              r_ovf;
  logic              r_udf;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_udf_set;
  logic [LVL_W-1:0]  w_level_nxt;

  // Accept/reject decisions look only at the current registered flags, so a full
  // channel refuses a push even when a pop is accepted on the same edge.
  assign w_push    = i_write_en && !r_full  && !i_flush;
  assign w_pop     = i_read_en  && !r_empty && !i_flush;
  assign w_ovf_set = i_write_en &&  r_full  && !i_flush;
  assign w_udf_set = i_read_en  &&  r_empty && !i_flush;

  always_comb begin
    w_level_nxt = r_level;
    if (reset || i_flush) begin
      w_level_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_q    <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      if (i_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_q    <= r_mem[r_rptr];
          r_rptr <= r_rptr + PTR_W'(1);
        end
      end
      // A new error on the same edge as a clear leaves the flag set.
      r_ovf <= w_ovf_set || (r_ovf && !i_err_clear);
      r_udf <= w_udf_set || (r_udf && !i_err_clear);
    end
    r_level <= w_level_nxt;
    r_full  <= (w_level_nxt == LVL_W'(DEPTH));
    r_empty <= (w_level_nxt == '0);
    r_af    <= (w_level_nxt >= LVL_W'(DEPTH - AF_MARGIN));
    r_ae    <= (w_level_nxt <= LVL_W'(AE_MARGIN));
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  assign o_q     = r_q;
  assign o_level = r_level;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_af    = r_af;
  assign o_ae    = r_ae;
  assign o_ovf   = r_ovf;
  assign o_udf   = r_udf;
endmodule

module sd_fifo_pair #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic         wishbone_clock,
  input  logic         reset,
  sd_fifo_pair_if.slave bus
);
  logic w_tx_full, w_tx_empty, w_tx_af, w_tx_ae, w_tx_ovf, w_tx_udf;
  logic w_rx_full, w_rx_empty, w_rx_af, w_rx_ae, w_rx_ovf, w_rx_udf;

  sd_fifo_chan #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN)
  ) u_tx (
    .clk(wishbone_clock), .reset(reset),
    .i_data(bus.tx_data_in), .i_write_en(bus.tx_write_en), .i_read_en(bus.tx_read_en),
    .i_flush(bus.flush_in[0]), .i_err_clear(bus.err_clear_in),
    .o_q(bus.tx_q_out), .o_level(bus.tx_level_out),
    .o_full(w_tx_full), .o_empty(w_tx_empty), .o_af(w_tx_af), .o_ae(w_tx_ae),
    .o_ovf(w_tx_ovf), .o_udf(w_tx_udf)
  );

  sd_fifo_chan #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN)
  ) u_rx (
    .clk(wishbone_clock), .reset(reset),
    .i_data(bus.rx_data_in), .i_write_en(bus.rx_write_en), .i_read_en(bus.rx_read_en),
    .i_flush(bus.flush_in[1]), .i_err_clear(bus.err_clear_in),
    .o_q(bus.rx_q_out), .o_level(bus.rx_level_out),
    .o_full(w_rx_full), .o_empty(w_rx_empty), .o_af(w_rx_af), .o_ae(w_rx_ae),
    .o_ovf(w_rx_ovf), .o_udf(w_rx_udf)
  );

  assign bus.status_out = {w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
  assign bus.almost_out = {w_rx_ae, w_rx_af, w_tx_ae, w_tx_af};
  assign bus.err_out    = {w_rx_udf, w_rx_ovf, w_tx_udf, w_tx_ovf};
endmodule

// File: tb/tb_sd_fifo_pair.sv
// Self-checking bench for sd_fifo_pair: a fixed vector table, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_sd_fifo_pair;
  localparam int DW = 32;
  localparam int DP = 16;
  localparam int AF = 2;
  localparam int AE = 2;
  localparam int LW = $clog2(DP + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sd_fifo_pair_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  sd_fifo_pair #(
    .DATA_W(DW), .DEPTH(DP), .AF_MARGIN(AF), .AE_MARGIN(AE)
  ) dut (
    .wishbone_clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  int total  = 0;
  int passed = 0;

  // Reference model: one queue per channel (index 0 = TX, 1 = RX).
  logic [DW-1:0] mq [2][$];
  logic [DW-1:0] mQ [2];
  bit            mOvf [2];
  bit            mUdf [2];

  typedef struct {
    logic          rst;
    logic [1:0]    we;
    logic [1:0]    re;
    logic [1:0]    fl;
    logic          clr;
    logic [DW-1:0] dtx;
    logic [DW-1:0] drx;
    logic [3:0]    st;
    logic [3:0]    al;
    logic [LW-1:0] txl;
    logic [LW-1:0] rxl;
    logic [3:0]    err;
    logic [DW-1:0] txq;
    logic [DW-1:0] rxq;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic modelStep(input logic r, input logic [1:0] we, input logic [1:0] re,
                           input logic [DW-1:0] dtx, input logic [DW-1:0] drx,
                           input logic [1:0] fl, input logic clr);
    logic [DW-1:0] d;
    bit wasFull, wasEmpty;
    for (int ch = 0; ch < 2; ch++) begin
      d = (ch == 0) ? dtx : drx;
      if (r) begin
        mq[ch].delete();
        mQ[ch] = '0;
        mOvf[ch] = 1'b0;
        mUdf[ch] = 1'b0;
      end else if (fl[ch]) begin
        mq[ch].delete();
        mOvf[ch] = mOvf[ch] && !clr;
        mUdf[ch] = mUdf[ch] && !clr;
      end else begin
        wasFull  = (mq[ch].size() == DP);
        wasEmpty = (mq[ch].size() == 0);
        if (re[ch] && !wasEmpty) mQ[ch] = mq[ch].pop_front();
        if (we[ch] && !wasFull) mq[ch].push_back(d);
        mOvf[ch] = (we[ch] && wasFull) || (mOvf[ch] && !clr);
        mUdf[ch] = (re[ch] && wasEmpty) || (mUdf[ch] && !clr);
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] we, input logic [1:0] re,
                               input logic [DW-1:0] dtx, input logic [DW-1:0] drx,
                               input logic [1:0] fl, input logic clr);
    rst              = r;
    bus.tx_write_en  = we[0];
    bus.rx_write_en  = we[1];
    bus.tx_read_en   = re[0];
    bus.rx_read_en   = re[1];
    bus.tx_data_in   = dtx;
    bus.rx_data_in   = drx;
    bus.flush_in     = fl;
    bus.err_clear_in = clr;
    @(posedge clk);
    modelStep(r, we, re, dtx, drx, fl, clr);
    #1;
  endtask

  task automatic checkOutput();
    int s0, s1;
    s0 = mq[0].size();
    s1 = mq[1].size();
    check("status", {28'd0, bus.status_out}, {28'd0, s1 == 0, s1 == DP, s0 == 0, s0 == DP});
    check("almost", {28'd0, bus.almost_out}, {28'd0, s1 <= AE, s1 >= DP - AF, s0 <= AE, s0 >= DP - AF});
    check("tx_level", DW'(bus.tx_level_out), DW'(s0));
    check("rx_level", DW'(bus.rx_level_out), DW'(s1));
    check("tx_q", bus.tx_q_out, mQ[0]);
    check("rx_q", bus.rx_q_out, mQ[1]);
    check("err", {28'd0, bus.err_out}, {28'd0, mUdf[1], mOvf[1], mUdf[0], mOvf[0]});
  endtask

  task automatic step(input logic r, input logic [1:0] we, input logic [1:0] re,
                      input logic [DW-1:0] dtx, input logic [DW-1:0] drx,
                      input logic [1:0] fl, input logic clr);
    applyStimulus(r, we, re, dtx, drx, fl, clr);
    checkOutput();
  endtask

  initial begin
    bus.tx_write_en = 0; bus.rx_write_en = 0; bus.tx_read_en = 0; bus.rx_read_en = 0;
    bus.tx_data_in = '0; bus.rx_data_in = '0; bus.flush_in = '0; bus.err_clear_in = 0;

    //            rst  we     re     fl     clr   dtx     drx     st       al       txl rxl err      txq     rxq
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 32'h00, 32'h00, 4'b1010, 4'b1010, 0, 0, 4'b0000, 32'h00, 32'h00};
    vecs[1]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 32'h11, 32'h00, 4'b1000, 4'b1010, 1, 0, 4'b0000, 32'h00, 32'h00};
    vecs[2]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 32'h22, 32'h00, 4'b1000, 4'b1010, 2, 0, 4'b0000, 32'h00, 32'h00};
    vecs[3]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 32'h33, 32'h00, 4'b1000, 4'b1000, 3, 0, 4'b0000, 32'h00, 32'h00};
    vecs[4]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 32'h00, 32'h00, 4'b1000, 4'b1010, 2, 0, 4'b0000, 32'h11, 32'h00};
    vecs[5]  = '{1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 32'h44, 32'h00, 4'b1000, 4'b1010, 2, 0, 4'b0000, 32'h22, 32'h00};
    vecs[6]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 32'h00, 32'h00, 4'b1000, 4'b1010, 1, 0, 4'b0000, 32'h33, 32'h00};
    vecs[7]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 32'h00, 32'h00, 4'b1010, 4'b1010, 0, 0, 4'b0000, 32'h44, 32'h00};
    vecs[8]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 32'h00, 32'h00, 4'b1010, 4'b1010, 0, 0, 4'b0010, 32'h44, 32'h00};
    vecs[9]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 32'h00, 32'h00, 4'b1010, 4'b1010, 0, 0, 4'b0000, 32'h44, 32'h00};
    vecs[10] = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 32'h00, 32'h55, 4'b0010, 4'b1010, 0, 1, 4'b0000, 32'h44, 32'h00};
    vecs[11] = '{1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 32'h00, 32'h66, 4'b0010, 4'b1010, 0, 2, 4'b0000, 32'h44, 32'h00};
    vecs[12] = '{1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 32'h00, 32'h00, 4'b0010, 4'b1010, 0, 1, 4'b0000, 32'h44, 32'h55};
    vecs[13] = '{1'b0, 2'b11, 2'b00, 2'b10, 1'b0, 32'h88, 32'h77, 4'b1000, 4'b1010, 1, 0, 4'b0000, 32'h44, 32'h55};
    vecs[14] = '{1'b0, 2'b00, 2'b10, 2'b10, 1'b0, 32'h00, 32'h00, 4'b1000, 4'b1010, 1, 0, 4'b0000, 32'h44, 32'h55};
    vecs[15] = '{1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 32'h99, 32'h00, 4'b1010, 4'b1010, 0, 0, 4'b0000, 32'h00, 32'h00};

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].dtx, vecs[i].drx, vecs[i].fl, vecs[i].clr);
      check($sformatf("vec%0d_status", i), {28'd0, bus.status_out}, {28'd0, vecs[i].st});
      check($sformatf("vec%0d_almost", i), {28'd0, bus.almost_out}, {28'd0, vecs[i].al});
      check($sformatf("vec%0d_txl", i), DW'(bus.tx_level_out), DW'(vecs[i].txl));
      check($sformatf("vec%0d_rxl", i), DW'(bus.rx_level_out), DW'(vecs[i].rxl));
      check($sformatf("vec%0d_err", i), {28'd0, bus.err_out}, {28'd0, vecs[i].err});
      check($sformatf("vec%0d_txq", i), bus.tx_q_out, vecs[i].txq);
      check($sformatf("vec%0d_rxq", i), bus.rx_q_out, vecs[i].rxq);
    end

    // Fill TX to full; almost-full must appear from level DEPTH-AF_MARGIN.
    step(1, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    for (int i = 0; i < DP; i++) begin
      step(0, 2'b01, 2'b00, DW'(32'hA0 + i), 0, 2'b00, 0);
      check("t1_tx_af", {31'd0, bus.almost_out[0]}, {31'd0, (i + 1) >= (DP - AF)});
    end
    check("t1_tx_full", {31'd0, bus.status_out[0]}, 32'd1);
    check("t1_tx_level", DW'(bus.tx_level_out), 32'd16);

    // Overflow while full, then drain in order.
    step(0, 2'b01, 2'b00, 32'hDEAD, 0, 2'b00, 0);
    check("t2_ovf", {31'd0, bus.err_out[0]}, 32'd1);
    check("t2_level", DW'(bus.tx_level_out), 32'd16);
    for (int i = 0; i < DP; i++) begin
      step(0, 2'b00, 2'b01, 0, 0, 2'b00, 0);
      check("t2_pop_data", bus.tx_q_out, DW'(32'hA0 + i));
    end

    // Simultaneous push+pop at level 5, then on an empty channel.
    step(0, 2'b00, 2'b00, 0, 0, 2'b00, 1);
    for (int i = 0; i < 5; i++) step(0, 2'b01, 2'b00, DW'(32'hB0 + i), 0, 2'b00, 0);
    for (int i = 0; i < 3; i++) step(0, 2'b01, 2'b01, DW'(32'hC0 + i), 0, 2'b00, 0);
    check("t3_level5", DW'(bus.tx_level_out), 32'd5);
    for (int i = 0; i < 5; i++) step(0, 2'b00, 2'b01, 0, 0, 2'b00, 0);
    check("t3_last", bus.tx_q_out, 32'hC2);
    step(0, 2'b01, 2'b01, 32'hE1, 0, 2'b00, 0);
    check("t3_udf", {31'd0, bus.err_out[1]}, 32'd1);
    check("t3_level1", DW'(bus.tx_level_out), 32'd1);

    // RX flush with a concurrent write; TX must keep its entry.
    for (int i = 0; i < 7; i++) step(0, 2'b10, 2'b00, 0, DW'(32'hD0 + i), 2'b00, 0);
    step(0, 2'b10, 2'b00, 0, 32'hFF, 2'b10, 0);
    check("t4_rx_level", DW'(bus.rx_level_out), 32'd0);
    check("t4_rx_empty", {31'd0, bus.status_out[3]}, 32'd1);
    check("t4_rx_ovf", {31'd0, bus.err_out[2]}, 32'd0);
    check("t4_tx_level", DW'(bus.tx_level_out), 32'd1);

    // Clear and new overflow on the same edge: set wins.
    step(1, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    for (int i = 0; i < DP; i++) step(0, 2'b01, 2'b00, DW'(i), 0, 2'b00, 0);
    step(0, 2'b01, 2'b00, 32'h1, 0, 2'b00, 0);
    step(0, 2'b01, 2'b00, 32'h2, 0, 2'b00, 1);
    check("t5_set_wins", {31'd0, bus.err_out[0]}, 32'd1);
    step(0, 2'b00, 2'b00, 0, 0, 2'b00, 1);
    check("t5_cleared", {31'd0, bus.err_out[0]}, 32'd0);

    // 40 pushes / 40 pops interleaved across the pointer wrap.
    step(1, 2'b00, 2'b00, 0, 0, 2'b00, 0);
    for (int i = 0; i < 10; i++) step(0, 2'b11, 2'b00, DW'(32'h100 + i), DW'(32'h200 + i), 2'b00, 0);
    for (int i = 10; i < 40; i++) step(0, 2'b11, 2'b11, DW'(32'h100 + i), DW'(32'h200 + i), 2'b00, 0);
    for (int i = 0; i < 10; i++) step(0, 2'b00, 2'b11, 0, 0, 2'b00, 0);
    check("t6_tx_last", bus.tx_q_out, 32'h127);
    check("t6_rx_last", bus.rx_q_out, 32'h227);

    // Random traffic with rare flush/clear and a reset mid-stream.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] we, re, fl;
      logic       clr, r;
      we  = 2'($urandom);
      re  = 2'($urandom);
      fl  = {($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0)};
      clr = ($urandom_range(0, 15) == 0);
      r   = (i == 300);
      step(r, we, re, $urandom, $urandom, fl, clr);
      if (r) begin
        check("rnd_rst_status", {28'd0, bus.status_out}, 32'b1010);
        check("rnd_rst_almost", {28'd0, bus.almost_out}, 32'b1010);
        check("rnd_rst_err", {28'd0, bus.err_out}, 32'd0);
        check("rnd_rst_txq", bus.tx_q_out, 32'd0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
